// File: rtl/mod_n_counter_if.sv
// Control/status bundle for mod_n_counter.
//   master modport: the controlling side; drives clr, en, up, load, din, oneshot
//                   and observes q, qbar, co, wrap, done, load_err.
//   slave modport : the counter itself; the mirror image of master.
// WIDTH must match the WIDTH of the counter the interface is attached to.
interface mod_n_counter_if #(
    parameter int WIDTH = 4
);
    logic             clr;
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] din;
    logic             oneshot;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qbar;
    logic             co;
    logic             wrap;
    logic             done;
    logic             load_err;

    modport master (
        output clr, en, up, load, din, oneshot,
        input  q, qbar, co, wrap, done, load_err
    );

    modport slave (
        input  clr, en, up, load, din, oneshot,
        output q, qbar, co, wrap, done, load_err
    );
endinterface

// File: rtl/mod_n_counter.sv
// Synchronous modulo-MOD up/down counter with parallel load, synchronous clear,
// one-shot mode and a combinational carry/borrow for cascading stages.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset (q=0, all flags 0)
//   bus  : mod_n_counter_if.slave
//          in : clr, en, up, load, din, oneshot
//          out: q, qbar, co (comb), wrap (1-cycle pulse), done (sticky),
//               load_err (1-cycle pulse)
// Priority at each edge: rst > clr > load > count > hold.
module mod_n_counter #(
    parameter int MOD   = 13,
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    mod_n_counter_if.slave       bus
);

    if (MOD < 2 || MOD > (2 ** WIDTH)) begin : g_bad_params
        $error("mod_n_counter: MOD must lie in 2..2**WIDTH");
    end

    localparam logic [WIDTH-1:0] MAXV  = WIDTH'(MOD - 1);
    // One extra bit so MOD == 2**WIDTH is still representable for the range test.
    localparam logic [WIDTH:0]   MOD_X = (WIDTH + 1)'(MOD);

    logic [WIDTH-1:0] q_r;
    logic             wrap_r;
    logic             done_r;
    logic             load_err_r;
    logic             at_term;
    logic             din_ok;

    // Non-terminal steps only; the terminal value is handled explicitly so the
    // arithmetic never depends on modulo-2**WIDTH rollover.
    function automatic logic [WIDTH-1:0] step_up(input logic [WIDTH-1:0] v);
        return v + WIDTH'(1);
    endfunction

    function automatic logic [WIDTH-1:0] step_down(input logic [WIDTH-1:0] v);
        return v - WIDTH'(1);
    endfunction

    assign at_term = bus.up ? (q_r == MAXV) : (q_r == '0);
    assign din_ok  = ({1'b0, bus.din} < MOD_X);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_r        <= '0;
            wrap_r     <= 1'b0;
            done_r     <= 1'b0;
            load_err_r <= 1'b0;
        end else begin
            // Pulses default low; only the causing edge raises them.
            wrap_r     <= 1'b0;
            load_err_r <= 1'b0;
            if (bus.clr) begin
                q_r    <= '0;
                done_r <= 1'b0;
            end else if (bus.load) begin
                done_r <= 1'b0;
                if (din_ok) begin
                    q_r <= bus.din;
                end else begin
                    q_r        <= '0;
                    load_err_r <= 1'b1;
                end
            end else if (bus.en && !done_r) begin
                if (at_term) begin
                    if (bus.oneshot) begin
                        // Halt on the terminal value instead of wrapping.
                        done_r <= 1'b1;
                    end else begin
                        q_r    <= bus.up ? '0 : MAXV;
                        wrap_r <= 1'b1;
                    end
                end else begin
                    q_r <= bus.up ? step_up(q_r) : step_down(q_r);
                end
            end
        end
    end

    assign bus.q        = q_r;
    assign bus.qbar     = ~q_r;
    // en is ignored while rst is high, so co is forced low during reset.
    assign bus.co       = bus.en & at_term & ~done_r & ~rst;
    assign bus.wrap     = wrap_r;
    assign bus.done     = done_r;
    assign bus.load_err = load_err_r;

endmodule

// File: tb/tb_mod_n_counter.sv
module tb_mod_n_counter;

    logic clk;
    logic rst;

    mod_n_counter_if #(.WIDTH(4)) dif ();
    mod_n_counter_if #(.WIDTH(4)) cif1 ();
    mod_n_counter_if #(.WIDTH(3)) cif2 ();

    mod_n_counter #(.MOD(13), .WIDTH(4)) dut (.clk(clk), .rst(rst), .bus(dif.slave));
    mod_n_counter #(.MOD(13), .WIDTH(4)) c1  (.clk(clk), .rst(rst), .bus(cif1.slave));
    mod_n_counter #(.MOD(5),  .WIDTH(3)) c2  (.clk(clk), .rst(rst), .bus(cif2.slave));

    // Cascade: second stage advances on the first stage's carry.
    assign cif2.en = cif1.co;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] q;
        logic       w;
        logic       d;
        logic       le;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Drive one cycle of inputs (just after a falling edge), check the
    // combinational carry, queue the state expected after the next rising edge.
    task automatic step(input logic c, input logic l, input logic [3:0] d,
                        input logic e, input logic u, input logic os,
                        input logic [3:0] eq, input logic ew, input logic ed,
                        input logic ele, input logic eco);
        exp_t x;
        dif.clr = c; dif.load = l; dif.din = d;
        dif.en = e; dif.up = u; dif.oneshot = os;
        #1;
        chk("co", {31'd0, dif.co}, {31'd0, eco});
        x.q = eq; x.w = ew; x.d = ed; x.le = ele;
        sb.push_back(x);
        @(negedge clk);
    endtask

    // Monitor: the counter presents a new state after every rising edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                chk("q",        {28'd0, dif.q},     {28'd0, x.q});
                chk("qbar",     {28'd0, dif.qbar},  {28'd0, ~x.q});
                chk("wrap",     {31'd0, dif.wrap},  {31'd0, x.w});
                chk("done",     {31'd0, dif.done},  {31'd0, x.d});
                chk("load_err", {31'd0, dif.load_err}, {31'd0, x.le});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        dif.clr = 0; dif.load = 0; dif.din = 0; dif.en = 1; dif.up = 0; dif.oneshot = 0;
        cif1.clr = 0; cif1.load = 0; cif1.din = 0; cif1.en = 0; cif1.up = 1; cif1.oneshot = 0;
        cif2.clr = 0; cif2.load = 0; cif2.din = 0; cif2.up = 1; cif2.oneshot = 0;
        #1;
        // Reset state; en=1, up=0, q=0 would give co=1 if rst were not gating it.
        chk("rst_q",    {28'd0, dif.q},    32'h0);
        chk("rst_qbar", {28'd0, dif.qbar}, 32'hF);
        chk("rst_flags", {29'd0, dif.wrap, dif.done, dif.load_err}, 32'h0);
        chk("rst_co",   {31'd0, dif.co},   32'h0);
        dif.en = 0; dif.up = 1;
        @(negedge clk);
        rst = 1'b0;

        // Count up to 7, then reset asynchronously between edges.
        for (int i = 1; i <= 7; i++)
            step(0, 0, 0, 1, 1, 0, 4'(i), 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        chk("arst_q",    {28'd0, dif.q},    32'h0);
        chk("arst_qbar", {28'd0, dif.qbar}, 32'hF);
        chk("arst_flags", {29'd0, dif.wrap, dif.done, dif.load_err}, 32'h0);
        #1;
        rst = 1'b0;
        step(0, 0, 0, 1, 1, 0, 4'd1, 0, 0, 0, 0);

        // Up wrap over 14 edges from 0.
        step(1, 0, 0, 0, 1, 0, 4'd0, 0, 0, 0, 0);
        for (int k = 1; k <= 14; k++)
            step(0, 0, 0, 1, 1, 0, 4'(k % 13), (k == 13), 0, 0, (k == 13));

        // Down wrap: load 2 then 2->1->0->12->11.
        step(0, 1, 4'd2, 1, 0, 0, 4'd2,  0, 0, 0, 0);
        step(0, 0, 0,    1, 0, 0, 4'd1,  0, 0, 0, 0);
        step(0, 0, 0,    1, 0, 0, 4'd0,  0, 0, 0, 0);
        step(0, 0, 0,    1, 0, 0, 4'd12, 1, 0, 0, 1);
        step(0, 0, 0,    1, 0, 0, 4'd11, 0, 0, 0, 0);

        // Loads: override en, out-of-range, boundary, clr beating load.
        step(0, 1, 4'd5,  1, 1, 0, 4'd5,  0, 0, 0, 0);
        step(0, 1, 4'd14, 0, 1, 0, 4'd0,  0, 0, 1, 0);
        step(0, 0, 0,     0, 1, 0, 4'd0,  0, 0, 0, 0);
        step(0, 1, 4'd13, 0, 1, 0, 4'd0,  0, 0, 1, 0);
        step(0, 1, 4'd12, 0, 1, 0, 4'd12, 0, 0, 0, 0);
        step(1, 1, 4'd9,  0, 1, 0, 4'd0,  0, 0, 0, 0);
        step(1, 1, 4'd14, 0, 1, 0, 4'd0,  0, 0, 0, 0);

        // One-shot up from 10.
        step(0, 1, 4'd10, 0, 1, 1, 4'd10, 0, 0, 0, 0);
        step(0, 0, 0,     1, 1, 1, 4'd11, 0, 0, 0, 0);
        step(0, 0, 0,     1, 1, 1, 4'd12, 0, 0, 0, 0);
        step(0, 0, 0,     1, 1, 1, 4'd12, 0, 1, 0, 1);
        step(0, 0, 0,     1, 1, 1, 4'd12, 0, 1, 0, 0);
        // oneshot dropped while done: still sticky.
        step(0, 0, 0,     1, 1, 0, 4'd12, 0, 1, 0, 0);
        step(0, 1, 4'd3,  1, 1, 0, 4'd3,  0, 0, 0, 0);
        step(0, 0, 0,     1, 1, 0, 4'd4,  0, 0, 0, 0);
        step(0, 0, 0,     1, 1, 0, 4'd5,  0, 0, 0, 0);
        // Direction change applies on that edge.
        step(0, 0, 0,     1, 0, 0, 4'd4,  0, 0, 0, 0);

        // One-shot down to 0, then clr releases done.
        step(0, 1, 4'd1,  0, 0, 1, 4'd1,  0, 0, 0, 0);
        step(0, 0, 0,     1, 0, 1, 4'd0,  0, 0, 0, 0);
        step(0, 0, 0,     1, 0, 1, 4'd0,  0, 1, 0, 1);
        step(1, 0, 0,     0, 0, 1, 4'd0,  0, 0, 0, 0);
        dif.clr = 0; dif.oneshot = 0;
        @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);

        // Cascade 13 x 5.
        cif1.en = 1'b1;
        for (int k = 1; k <= 65; k++) begin
            @(negedge clk);
            if (k == 12 || k == 13 || k == 64 || k == 65) begin
                chk("casc_q1", {28'd0, cif1.q}, 32'(k % 13));
                chk("casc_q2", {29'd0, cif2.q}, 32'((k / 13) % 5));
            end
        end
        cif1.en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
